pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the multi-cycle/pipelined CPU datapath, the general replacement for the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload bundle with a valid/ready handshake instead of a global stall vector. It inserts a configurable bubble (NOP) value whenever it holds no valid instruction. It supports synchronous flush for exceptions and branches, an optional skid buffer for a registered `in_ready`, and a saturating bubble-cycle performance counter.

## Interface
Parameters:
- `DATA_W`, 32: payload width in bits (wd, wreg, wdata, hi/lo, aluop, cp0 fields, etc. concatenated by the instantiating stage).
- `BUBBLE`, `{DATA_W{1'b0}}`: value driven on `out_data` when no valid entry is held (NOP encoding).
- `CNT_W`, 16: bubble counter width.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous discard of all held entries.
- `in_valid` in 1: upstream stage presents an instruction.
- `in_ready` out 1: block can accept this cycle.
- `in_data` in `DATA_W`: upstream payload.
- `out_valid` out 1: downstream payload valid.
- `out_ready` in 1: downstream accepts this cycle (inverse of a downstream stall).
- `out_data` out `DATA_W`: payload, equal to `BUBBLE` when `out_valid`=0.
- `occupancy` out 2: entries held (0..1 without skid, 0..2 with skid).
- `bubble_cnt` out `CNT_W`: saturating count of cycles with `out_ready`=1 and `out_valid`=0.

## Operation
- Transfer in: `in_valid && in_ready` at an edge. Transfer out: `out_valid && out_ready` at an edge.
- Priority per edge: `rst` > `flush` > normal transfer.
- Reset values:
  - `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0, `bubble_cnt`=0.
  - `in_ready`=1 from the first cycle after reset. While `rst` is high, `in_ready` is forced 0.
- Flush:
  - Clears main and skid entries.
  - Drops any input presented that cycle.
  - `bubble_cnt` is unaffected.
- Hold: while `out_valid && !out_ready`, `out_data` and `out_valid` are held stable (no change, no bubble).
- Main register only (no skid):
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - On transfer in, main loads `in_data`. On transfer out without transfer in, main goes empty.
- `bubble_cnt`:
  - Increments when `out_ready && !out_valid`.
  - Saturates at all-ones; does not wrap.
  - Cleared only by `rst`.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput is 1 transfer per cycle in both modes, including continuous streaming with `out_ready`=1.
- Without skid, `out_ready` to `in_ready` is a combinational path, one gate level.
- With skid:
  - `in_ready` is a register output, equal to skid empty.
  - If main is full, `out_ready`=0 and a transfer in occurs, the data lands in skid. `in_ready` falls after that edge.
  - When `out_ready` returns, skid moves into main in the same edge that main drains, and `in_ready` rises after that edge.
  - Order is always preserved: skid data is never emitted before main data.
- Simultaneous transfer in and out with main full and skid empty: main takes `in_data` and `occupancy` stays 1.
- `occupancy` updates on the same edge as the transfers.

## Configuration
- `PIPE_SKID_EN` defined: two-entry (main + skid) buffer, registered `in_ready`, `occupancy` range 0..2.
- `PIPE_SKID_EN` undefined: single main register, combinational `in_ready`, `occupancy` range 0..1, and the skid logic is absent.
- Port list is identical in both builds.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF. Required: `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=0 during reset; `in_ready`=1 the cycle after release; `bubble_cnt`=0 at release.
- Streaming: 8 back-to-back words 0x1..0x8 with `out_ready`=1. Required: each word appears exactly 1 cycle later, in order, with no gaps.
- Backpressure: drop `out_ready` for 3 cycles mid-stream.
  - No skid: `out_data` holds 0x3 and `in_ready`=0 while stalled.
  - Skid: 0x4 is captured, `occupancy`=2, `in_ready`=0 one cycle later.
  - Both: 0x3, 0x4, 0x5 are emitted in order after release, with no loss or duplication.
- Flush during stall: entries held (`occupancy`=2 with skid), pulse `flush` with `in_valid`=1 and `in_data`=0x99. Required: next cycle `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0; 0x99 is never emitted.
- Bubble counter: `CNT_W`=4, `out_ready`=1, `in_valid`=0 for 20 cycles. Required: `bubble_cnt` reaches 15 and stays 15; no increment during cycles with `out_valid`=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble insertion
// and saturating bubble counter. Define PIPE_SKID_EN for the two-entry skid variant.
module pipe_stage_reg #(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [1:0]        occ_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [1:0]        occ_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              accept_s;
  logic              pop_s;

`ifdef PIPE_SKID_EN
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;

  // Registered ready: the stage can always take one more word while skid is empty.
  assign in_ready = !rst && !skid_valid_r;
`else
  assign in_ready = !rst && (!main_valid_r || out_ready);
`endif

  assign accept_s   = in_valid && in_ready;
  assign pop_s      = main_valid_r && out_ready;
  assign out_valid  = main_valid_r;
  assign out_data   = main_data_r;
  assign occupancy  = occ_r;
  assign bubble_cnt = cnt_r;

`ifdef PIPE_SKID_EN
  // Next-state for main and skid entries; skid always drains into main first.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      main_valid_s = 1'b0;
      main_data_s  = BUBBLE;
      skid_valid_s = 1'b0;
      skid_data_s  = BUBBLE;
    end else if (!main_valid_r) begin
      if (accept_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (pop_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
        skid_data_s  = BUBBLE;
      end else if (accept_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
        main_data_s  = BUBBLE;
      end
    end else begin
      if (accept_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = in_data;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
    occ_s = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
  end
`else
  // Next-state for the single main entry; a bubble is loaded whenever it empties.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    if (flush) begin
      main_valid_s = 1'b0;
      main_data_s  = BUBBLE;
    end else if (accept_s) begin
      main_valid_s = 1'b1;
      main_data_s  = in_data;
    end else if (pop_s) begin
      main_valid_s = 1'b0;
      main_data_s  = BUBBLE;
    end else begin
      main_valid_s = main_valid_r;
    end
    occ_s = {1'b0, main_valid_s};
  end
`endif

  // Saturating count of cycles where downstream was ready but nothing was offered.
  always_comb begin
    cnt_s = cnt_r;
    if (out_ready && !main_valid_r && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_data_r  <= BUBBLE;
      occ_r        <= 2'd0;
      cnt_r        <= {CNT_W{1'b0}};
`ifdef PIPE_SKID_EN
      skid_valid_r <= 1'b0;
      skid_data_r  <= BUBBLE;
`endif
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      occ_r        <= occ_s;
      cnt_r        <= cnt_s;
`ifdef PIPE_SKID_EN
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model of the stage.
// Works for both builds (PIPE_SKID_EN defined or not).
module tb_pipe_stage_reg;

  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] BUB    = 32'h0000_0013;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = 32'h0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] q[$];
  int          cnt_m = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  wire [39:0] dut_vec = {out_valid, out_data, in_ready, occupancy, bubble_cnt};

  function automatic logic model_ir();
    if (rst) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic [39:0] exp_vec();
    logic ov;
    logic [31:0] od;
    ov = q.size() > 0;
    od = ov ? q[0] : BUB;
    return {ov, od, model_ir(), 2'(q.size()), 4'(cnt_m)};
  endfunction

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  // Advance the model by the rules of the stage, then let the edge happen.
  task automatic tick();
    logic ov, acc;
    ov  = q.size() > 0;
    acc = in_valid && model_ir();
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (out_ready && !ov && cnt_m < 15) cnt_m++;
      if (flush) q.delete();
      else begin
        if (ov && out_ready) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_pre: got %b exp 0", in_ready); end
    else passed++;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_hold: got %h exp %h", dut_vec, exp_vec()); end
      else passed++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || bubble_cnt !== 4'd0 || out_data !== BUB) begin
      fails++; $display("FAIL reset_release: got rdy=%b cnt=%0d data=%h exp rdy=1 cnt=0 data=%h",
                        in_ready, bubble_cnt, out_data, BUB);
    end else passed++;
    tick();
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, i <= 8, (i <= 8) ? 32'(i) : 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL streaming[%0d]: got %h exp %h", i, dut_vec, exp_vec()); end
      else passed++;
      if (i >= 2 && i <= 9) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'(i - 1)) begin
          fails++; $display("FAIL stream_latency[%0d]: got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 32'(i - 1));
        end else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic [31:0] seen[$];
    logic ordy, acc;
    for (int c = 0; c < 16; c++) begin
      ordy = !(c >= 3 && c <= 5);
      drive(1'b0, 1'b0, idx < 8, (idx < 8) ? 32'(idx + 1) : 32'h0, ordy);
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL backpressure[%0d]: got %h exp %h", c, dut_vec, exp_vec()); end
      else passed++;
      if (c == 5) begin
        checks++;
        if (out_data !== 32'h3 || in_ready !== 1'b0 || occupancy !== 2'(CAP)) begin
          fails++; $display("FAIL stall_state: got d=%h rdy=%b occ=%0d exp d=3 rdy=0 occ=%0d",
                            out_data, in_ready, occupancy, CAP);
        end else passed++;
      end
      if (out_valid && ordy) seen.push_back(out_data);
      acc = in_valid && model_ir();
      tick();
      if (acc) idx++;
    end
    checks++;
    if (seen.size() != 8) begin fails++; $display("FAIL bp_count: got %0d exp 8", seen.size()); end
    else passed++;
    for (int k = 0; k < seen.size() && k < 8; k++) begin
      checks++;
      if (seen[k] !== 32'(k + 1)) begin fails++; $display("FAIL bp_order[%0d]: got %h exp %h", k, seen[k], 32'(k + 1)); end
      else passed++;
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 32'hA1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 32'hA2, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 32'h99, 1'b0);
    checks++;
    if (occupancy !== 2'(CAP)) begin fails++; $display("FAIL flush_pre_occ: got %0d exp %0d", occupancy, CAP); end
    else passed++;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec() || out_valid !== 1'b0 || out_data !== BUB || occupancy !== 2'd0) begin
        fails++; $display("FAIL flush_after[%0d]: got %h exp %h", i, dut_vec, exp_vec());
      end else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    logic f, r, iv, ordy;
    for (int c = 0; c < 300; c++) begin
      r    = ($urandom_range(63) == 0);
      f    = ($urandom_range(15) == 0);
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      drive(r, f, iv, $urandom, ordy);
      if (!r) begin
        checks++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random[%0d]: got %h exp %h", c, dut_vec, exp_vec()); end
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_bubble_cnt();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i < 3, 32'h50 + 32'(i), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL bubble_stream[%0d]: got %h exp %h", i, dut_vec, exp_vec()); end
      else passed++;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL bubble_idle[%0d]: got %h exp %h", i, dut_vec, exp_vec()); end
      else passed++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bubble_cnt !== 4'd15) begin fails++; $display("FAIL bubble_sat: got %0d exp 15", bubble_cnt); end
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    test_bubble_cnt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
